// File: rtl/alu_arb_pkg.sv
// Shared types and constants for the two-requester ALU arbiter.
// Latency/backpressure: n/a (declarations only).
// Widths and opcodes come from aluop.svh so they are defined in exactly one place.
`include "aluop.svh"

package alu_arb_pkg;

    localparam int REGDATASIZE = `REGDATASIZE;
    localparam int ALUOPSIZE   = `ALUOPSIZE;
    localparam int FLAGSIZE    = `FLAGSIZE;
    localparam int NREQ        = 2;

    localparam logic [ALUOPSIZE-1:0] OP_AND = `ALU_AND;
    localparam logic [ALUOPSIZE-1:0] OP_ORR = `ALU_ORR;
    localparam logic [ALUOPSIZE-1:0] OP_ADD = `ALU_ADD;
    localparam logic [ALUOPSIZE-1:0] OP_XOR = `ALU_XOR;
    localparam logic [ALUOPSIZE-1:0] OP_LSR = `ALU_LSR;
    localparam logic [ALUOPSIZE-1:0] OP_LSL = `ALU_LSL;
    localparam logic [ALUOPSIZE-1:0] OP_SUB = `ALU_SUB;

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } arb_state_t;

    // One-entry output register contents.
    typedef struct packed {
        logic [REGDATASIZE-1:0] result;
        logic [FLAGSIZE-1:0]    flags;
        logic                   owner;
    } resp_t;

endpackage

// File: rtl/Alu.sv
// Combinational ALU: AND/ORR/ADD/XOR/LSR/LSL/SUB with {N,Z,C,V} flags.
// Latency: combinational. Backpressure: none.
// Ports: alu_op, operand1, operand2 in; result, flags out. Undefined opcodes give result 0.
`include "aluop.svh"

module Alu (
    input  logic [`ALUOPSIZE-1:0]   alu_op,
    input  logic [`REGDATASIZE-1:0] operand1,
    input  logic [`REGDATASIZE-1:0] operand2,
    output logic [`REGDATASIZE-1:0] result,
    output logic [`FLAGSIZE-1:0]    flags
);

    localparam int DW   = `REGDATASIZE;
    localparam int SH_W = $clog2(DW);

    logic [DW:0] sum;
    logic        carry;
    logic        ovf;
    logic        shift_big;

    // Shift amounts of DW or more clear the result entirely.
    assign shift_big = |operand2[DW-1:SH_W];

    always_comb begin
        sum    = '0;
        result = '0;
        carry  = 1'b0;
        ovf    = 1'b0;
        case (alu_op)
            `ALU_AND: result = operand1 & operand2;
            `ALU_ORR: result = operand1 | operand2;
            `ALU_XOR: result = operand1 ^ operand2;
            `ALU_ADD: begin
                sum    = {1'b0, operand1} + {1'b0, operand2};
                result = sum[DW-1:0];
                carry  = sum[DW];
                ovf    = (operand1[DW-1] == operand2[DW-1]) && (result[DW-1] != operand1[DW-1]);
            end
            `ALU_SUB: begin
                // Carry set means no borrow (a >= b unsigned).
                sum    = {1'b0, operand1} + {1'b0, ~operand2} + {{DW{1'b0}}, 1'b1};
                result = sum[DW-1:0];
                carry  = sum[DW];
                ovf    = (operand1[DW-1] != operand2[DW-1]) && (result[DW-1] != operand1[DW-1]);
            end
            `ALU_LSR: result = shift_big ? '0 : (operand1 >> operand2[SH_W-1:0]);
            `ALU_LSL: result = shift_big ? '0 : (operand1 << operand2[SH_W-1:0]);
            default:  result = '0;
        endcase
        flags = {result[DW-1], (result == '0), carry, ovf};
    end

endmodule

// File: rtl/aluop.svh
// ALU opcode encodings and datapath widths shared by Alu and its users.
// Pure macro definitions; include-guarded so multiple includers are safe.
// No logic.
`ifndef ALUOP_SVH
`define ALUOP_SVH

`define REGDATASIZE 64
`define ALUOPSIZE   5
`define FLAGSIZE    4

`define ALU_AND 5'b00000
`define ALU_ORR 5'b00001
`define ALU_ADD 5'b00010
`define ALU_XOR 5'b00011
`define ALU_LSR 5'b00100
`define ALU_LSL 5'b01000
`define ALU_SUB 5'b10000

`endif

// File: rtl/rr_pick2.sv
// Two-way round-robin grant: a lone valid wins, on conflict the non-last wins.
// Latency: combinational. Backpressure: none, gating is done by the caller.
// Ports: valid[1:0] in, last in (index granted most recently), grant[1:0] out (one-hot or zero).
module rr_pick2 (
    input  logic [1:0] valid,
    input  logic       last,
    output logic [1:0] grant
);

    assign grant[0] = valid[0] & (~valid[1] | last);
    assign grant[1] = valid[1] & (~valid[0] | ~last);

endmodule

// File: rtl/alu_arbiter.sv
// Shares one Alu between two valid/ready requesters, round-robin, one-entry result register.
// Latency: accept at edge N -> resp_valid in cycle N+1; one op/cycle when the owner drains each cycle.
// Backpressure: a held result blocks new accepts until its owner takes it or flush clears it.
// Ports: clk, rst_n (sync, active-low), flush; req_valid/req_ready/req_op/req_a/req_b per requester;
//        resp_valid/resp_ready per requester, shared resp_result/resp_flags.
module alu_arbiter
    import alu_arb_pkg::*;
#(
    parameter int DATA_W = REGDATASIZE,
    parameter int OP_W   = ALUOPSIZE,
    parameter int FLAG_W = FLAGSIZE
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        flush,
    input  logic [NREQ-1:0]             req_valid,
    output logic [NREQ-1:0]             req_ready,
    input  logic [NREQ-1:0][OP_W-1:0]   req_op,
    input  logic [NREQ-1:0][DATA_W-1:0] req_a,
    input  logic [NREQ-1:0][DATA_W-1:0] req_b,
    output logic [NREQ-1:0]             resp_valid,
    input  logic [NREQ-1:0]             resp_ready,
    output logic [DATA_W-1:0]           resp_result,
    output logic [FLAG_W-1:0]           resp_flags
);

    arb_state_t state_q;
    resp_t      held_q;
    logic       last_q;

    logic [NREQ-1:0]    grant;
    logic               drain;
    logic               accept_win;
    logic               accept;
    logic               sel;
    logic [OP_W-1:0]    alu_op;
    logic [DATA_W-1:0]  alu_a;
    logic [DATA_W-1:0]  alu_b;
    logic [DATA_W-1:0]  alu_res;
    logic [FLAG_W-1:0]  alu_flags;

    rr_pick2 u_pick (
        .valid (req_valid),
        .last  (last_q),
        .grant (grant)
    );

    // The register can take a new op when empty, or when the held result leaves this cycle.
    assign drain      = (state_q == FULL) && resp_ready[held_q.owner];
    assign accept_win = rst_n && !flush && ((state_q == EMPTY) || drain);
    assign req_ready  = accept_win ? grant : '0;
    assign accept     = |req_ready;
    assign sel        = req_ready[1];

    assign alu_op = req_op[sel];
    assign alu_a  = req_a[sel];
    assign alu_b  = req_b[sel];

    Alu u_alu (
        .alu_op   (alu_op),
        .operand1 (alu_a),
        .operand2 (alu_b),
        .result   (alu_res),
        .flags    (alu_flags)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= EMPTY;
            held_q  <= '0;
            last_q  <= 1'b1;   // requester 0 wins the first conflict
        end else if (accept) begin
            state_q <= FULL;
            held_q  <= '{result: alu_res, flags: alu_flags, owner: sel};
            last_q  <= sel;
        end else if (flush || drain) begin
            // Result/flags are left as-is; they are meaningless once no response is valid.
            state_q <= EMPTY;
        end
    end

    assign resp_valid  = (state_q == FULL) ? (held_q.owner ? 2'b10 : 2'b01) : 2'b00;
    assign resp_result = held_q.result;
    assign resp_flags  = held_q.flags;

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed per-cycle vector table for the ALU arbiter plus a round-robin streaming sequence.
// Each table row gives one cycle of inputs and the outputs expected during that cycle.
// Expected results and flags ({N,Z,C,V}) are hand-computed.
module tb_alu_arbiter;
    import alu_arb_pkg::*;

    localparam int DW = REGDATASIZE;
    localparam int OW = ALUOPSIZE;
    localparam int FW = FLAGSIZE;

    localparam logic [63:0] NEG20 = 64'hFFFF_FFFF_FFFF_FFEC;
    localparam logic [63:0] FFF0  = 64'hFFFF_FFFF_FFFF_FFF0;

    logic                    clk = 1'b0;
    logic                    rst_n;
    logic                    flush;
    logic [NREQ-1:0]         req_valid;
    logic [NREQ-1:0]         req_ready;
    logic [NREQ-1:0][OW-1:0] req_op;
    logic [NREQ-1:0][DW-1:0] req_a;
    logic [NREQ-1:0][DW-1:0] req_b;
    logic [NREQ-1:0]         resp_valid;
    logic [NREQ-1:0]         resp_ready;
    logic [DW-1:0]           resp_result;
    logic [FW-1:0]           resp_flags;

    always #5 clk = ~clk;

    alu_arbiter #(.DATA_W(DW), .OP_W(OW), .FLAG_W(FW)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .flush       (flush),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_op      (req_op),
        .req_a       (req_a),
        .req_b       (req_b),
        .resp_valid  (resp_valid),
        .resp_ready  (resp_ready),
        .resp_result (resp_result),
        .resp_flags  (resp_flags)
    );

    typedef struct {
        logic          rst;
        logic          fl;
        logic [1:0]    vld;
        logic [1:0]    rrdy;
        logic [OW-1:0] op0;
        logic [63:0]   a0;
        logic [63:0]   b0;
        logic [OW-1:0] op1;
        logic [63:0]   a1;
        logic [63:0]   b1;
        logic [1:0]    exp_req_ready;
        logic [1:0]    exp_resp_valid;
        logic          chk;
        logic [63:0]   exp_res;
        logic [3:0]    exp_fl;
    } vec_t;

    vec_t tbl[$];
    int   n_vec = 0;
    int   n_err = 0;

    function automatic vec_t mk(input logic rst, input logic fl, input logic [1:0] vld, input logic [1:0] rrdy,
                                input logic [OW-1:0] op0, input logic [63:0] a0, input logic [63:0] b0,
                                input logic [OW-1:0] op1, input logic [63:0] a1, input logic [63:0] b1,
                                input logic [1:0] erdy, input logic [1:0] ervld,
                                input logic chk, input logic [63:0] eres, input logic [3:0] efl);
        vec_t v;
        v.rst = rst; v.fl = fl; v.vld = vld; v.rrdy = rrdy;
        v.op0 = op0; v.a0 = a0; v.b0 = b0; v.op1 = op1; v.a1 = a1; v.b1 = b1;
        v.exp_req_ready = erdy; v.exp_resp_valid = ervld;
        v.chk = chk; v.exp_res = eres; v.exp_fl = efl;
        return v;
    endfunction

    task automatic check(input string name, input int idx, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s[%0d]: got %h expected %h", name, idx, act, exp);
        end
    endtask

    task automatic drive(input logic rst, input logic fl, input logic [1:0] vld, input logic [1:0] rrdy,
                         input logic [OW-1:0] op0, input logic [63:0] a0, input logic [63:0] b0,
                         input logic [OW-1:0] op1, input logic [63:0] a1, input logic [63:0] b1);
        rst_n      = rst;
        flush      = fl;
        req_valid  = vld;
        resp_ready = rrdy;
        req_op[0]  = op0; req_a[0] = a0; req_b[0] = b0;
        req_op[1]  = op1; req_a[1] = a1; req_b[1] = b1;
    endtask

    initial begin
        // rst fl  vld    rrdy   op0     a0     b0    op1     a1  b1   erdy   ervld  chk res    flags
        // reset state
        tbl.push_back(mk(1, 0, 2'b00, 2'b00, OP_AND, 0,     0,    OP_AND, 0,  0,  2'b00, 2'b00, 1, 0,     4'b0000));
        // first conflict after reset: r0 wins
        tbl.push_back(mk(1, 0, 2'b11, 2'b00, OP_LSL, 3,     3,    OP_LSR, 16, 2,  2'b01, 2'b00, 0, 0,     4'b0000));
        tbl.push_back(mk(1, 0, 2'b10, 2'b00, OP_AND, 0,     0,    OP_LSR, 16, 2,  2'b00, 2'b01, 1, 24,    4'b0000));
        tbl.push_back(mk(1, 0, 2'b10, 2'b01, OP_AND, 0,     0,    OP_LSR, 16, 2,  2'b10, 2'b01, 1, 24,    4'b0000));
        // third conflict while r1 drains: r0 wins again
        tbl.push_back(mk(1, 0, 2'b11, 2'b10, OP_LSL, 3,     3,    OP_LSR, 16, 2,  2'b01, 2'b10, 1, 4,     4'b0000));
        tbl.push_back(mk(1, 0, 2'b00, 2'b01, OP_AND, 0,     0,    OP_AND, 0,  0,  2'b00, 2'b01, 1, 24,    4'b0000));
        // single SUB
        tbl.push_back(mk(1, 0, 2'b01, 2'b00, OP_SUB, 20,    4,    OP_AND, 0,  0,  2'b01, 2'b00, 0, 0,     4'b0000));
        tbl.push_back(mk(1, 0, 2'b00, 2'b01, OP_AND, 0,     0,    OP_AND, 0,  0,  2'b00, 2'b01, 1, 16,    4'b0010));
        // backpressure: r1 XOR held 5 cycles, r0 ADD pending
        tbl.push_back(mk(1, 0, 2'b10, 2'b00, OP_AND, 0,     0,    OP_XOR, 31, 16, 2'b10, 2'b00, 0, 0,     4'b0000));
        for (int i = 0; i < 5; i++)
            tbl.push_back(mk(1, 0, 2'b01, 2'b00, OP_ADD, 4, NEG20, OP_AND, 0,  0,  2'b00, 2'b10, 1, 15,    4'b0000));
        tbl.push_back(mk(1, 0, 2'b01, 2'b10, OP_ADD, 4,     NEG20, OP_AND, 0, 0,  2'b01, 2'b10, 1, 15,    4'b0000));
        tbl.push_back(mk(1, 0, 2'b00, 2'b01, OP_AND, 0,     0,    OP_AND, 0,  0,  2'b00, 2'b01, 1, FFF0,  4'b1000));
        // back-to-back ORR then AND
        tbl.push_back(mk(1, 0, 2'b01, 2'b01, OP_ORR, 31,    16,   OP_AND, 0,  0,  2'b01, 2'b00, 0, 0,     4'b0000));
        tbl.push_back(mk(1, 0, 2'b01, 2'b01, OP_AND, 31,    64,   OP_AND, 0,  0,  2'b01, 2'b01, 1, 31,    4'b0000));
        tbl.push_back(mk(1, 0, 2'b00, 2'b01, OP_AND, 0,     0,    OP_AND, 0,  0,  2'b00, 2'b01, 1, 0,     4'b0100));
        // flush while r1 holds and r0 waits
        tbl.push_back(mk(1, 0, 2'b10, 2'b00, OP_AND, 0,     0,    OP_XOR, 31, 16, 2'b10, 2'b00, 0, 0,     4'b0000));
        tbl.push_back(mk(1, 0, 2'b01, 2'b00, OP_ADD, 4,     NEG20, OP_AND, 0, 0,  2'b00, 2'b10, 1, 15,    4'b0000));
        tbl.push_back(mk(1, 1, 2'b01, 2'b10, OP_ADD, 4,     NEG20, OP_AND, 0, 0,  2'b00, 2'b10, 1, 15,    4'b0000));
        tbl.push_back(mk(1, 0, 2'b01, 2'b00, OP_ADD, 4,     NEG20, OP_AND, 0, 0,  2'b01, 2'b00, 0, 0,     4'b0000));
        tbl.push_back(mk(1, 0, 2'b00, 2'b01, OP_AND, 0,     0,    OP_AND, 0,  0,  2'b00, 2'b01, 1, FFF0,  4'b1000));
        // reset mid-op: r1 wins (last=0), then reset while FULL with requests pending
        tbl.push_back(mk(1, 0, 2'b11, 2'b00, OP_LSL, 3,     3,    OP_LSR, 16, 2,  2'b10, 2'b00, 0, 0,     4'b0000));
        tbl.push_back(mk(0, 0, 2'b11, 2'b00, OP_LSL, 3,     3,    OP_LSR, 16, 2,  2'b00, 2'b10, 1, 4,     4'b0000));
        tbl.push_back(mk(1, 0, 2'b11, 2'b00, OP_LSL, 3,     3,    OP_LSR, 16, 2,  2'b01, 2'b00, 1, 0,     4'b0000));
        tbl.push_back(mk(1, 0, 2'b00, 2'b01, OP_AND, 0,     0,    OP_AND, 0,  0,  2'b00, 2'b01, 1, 24,    4'b0000));

        // Power-on reset for two edges with requests asserted.
        drive(0, 0, 2'b11, 2'b11, OP_LSL, 3, 3, OP_LSR, 16, 2);
        #1;
        check("ready_in_reset", 0, {62'd0, req_ready}, 64'd0);
        repeat (2) @(posedge clk);

        foreach (tbl[i]) begin
            @(negedge clk);
            drive(tbl[i].rst, tbl[i].fl, tbl[i].vld, tbl[i].rrdy,
                  tbl[i].op0, tbl[i].a0, tbl[i].b0, tbl[i].op1, tbl[i].a1, tbl[i].b1);
            #4;
            check("req_ready", i, {62'd0, req_ready}, {62'd0, tbl[i].exp_req_ready});
            check("resp_valid", i, {62'd0, resp_valid}, {62'd0, tbl[i].exp_resp_valid});
            if (tbl[i].chk) begin
                check("resp_result", i, resp_result, tbl[i].exp_res);
                check("resp_flags", i, {60'd0, resp_flags}, {60'd0, tbl[i].exp_fl});
            end
        end

        // Both requesters continuously valid with resp_ready high: grants must alternate
        // every cycle, starting with r1 since r0 was granted last.
        begin
            logic [1:0] prev_grant;
            logic [1:0] exp_grant;
            prev_grant = 2'b00;
            for (int k = 0; k < 8; k++) begin
                @(negedge clk);
                drive(1, 0, 2'b11, 2'b11, OP_LSL, 3, 3, OP_LSR, 16, 2);
                #4;
                exp_grant = (k % 2 == 0) ? 2'b10 : 2'b01;
                check("rr_grant", k, {62'd0, req_ready}, {62'd0, exp_grant});
                check("rr_resp_valid", k, {62'd0, resp_valid}, {62'd0, prev_grant});
                if (prev_grant != 2'b00)
                    check("rr_result", k, resp_result, prev_grant[1] ? 64'd4 : 64'd24);
                prev_grant = exp_grant;
            end
        end

        // Stop requesting; the last result must drain within a small cycle budget.
        begin
            bit drained;
            drained = 1'b0;
            for (int k = 0; k < 4 && !drained; k++) begin
                @(negedge clk);
                drive(1, 0, 2'b00, 2'b11, OP_AND, 0, 0, OP_AND, 0, 0);
                @(posedge clk);
                #1;
                if (resp_valid == 2'b00) drained = 1'b1;
            end
            check("drain_timeout", 0, {63'd0, drained}, 64'd1);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/alu_arbiter.md
# alu_arbiter

Shares the single combinational `Alu` between two requesters (requester 0: execute stage, requester 1: address/branch-compare unit). Each requester uses valid/ready handshakes on its request and response channels. Arbitration is round-robin. The result and flags are captured in a one-entry output register. Response latency is one cycle, and back-to-back issue is supported when the held result drains in the same cycle.

## Interface
Parameters:
- `DATA_W`, default `REGDATASIZE` (64): operand/result width.
- `OP_W`, default `ALUOPSIZE` (5): ALU opcode width.
- `FLAG_W`, default `FLAGSIZE`: flags width, as produced by `Alu`.

Ports (clock and reset first):
- `clk`  in  1  single clock; all state updates on rising edge.
- `rst_n`  in  1  synchronous, active-low reset.
- `flush`  in  1  discard the held result; block acceptance this cycle.
- `req_valid`  in  [2]  request present, per requester.
- `req_ready`  out  [2]  request accepted this cycle, per requester.
- `req_op`  in  [2][OP_W]  `alu_op` encoding: AND 00000, ORR 00001, ADD 00010, XOR 00011, LSR 00100, LSL 01000, SUB 10000.
- `req_a`, `req_b`  in  [2][DATA_W]  operand1 and operand2.
- `resp_valid`  out  [2]  result held for that requester.
- `resp_ready`  in  [2]  requester takes the result.
- `resp_result`  out  DATA_W  held result, shared bus.
- `resp_flags`  out  FLAG_W  held flags, shared bus.

## Operation
- FSM states:
  - EMPTY: output register free.
  - FULL: result held for `owner`.
- Drain condition: `drain = FULL & resp_ready[owner]`.
- Accept window: `open = rst_n & ~flush & (EMPTY | drain)`.
- Grant (combinational from `req_valid` and `last`):
  - If only one requester is valid, it is granted.
  - If both are valid, grant the one that is not `last`.
  - `req_ready[i] = open & grant[i]`. At most one ready is high per cycle.
- On accept:
  - The selected op and operands drive the `Alu` combinationally in the same cycle.
  - `resp_result`, `resp_flags` and `owner` are registered at the edge.
  - `last` is set to the granted index.
  - State becomes FULL.
- On drain without accept: state becomes EMPTY. `resp_result`/`resp_flags` keep their values; they are don't-care when no response is valid.
- `resp_valid[i] = FULL & (owner == i)`.
- `flush`: FULL becomes EMPTY regardless of `resp_ready`. No accept happens that cycle, so `flush` takes priority over a simultaneous request.
- Opcodes are passed to `Alu` unchecked. Undefined opcodes yield whatever `Alu` produces; the arbiter adds no error path.
- The arbiter does no arithmetic. Width rules are those of `Alu` (64-bit wrap, shift amount from operand2).

## Timing
- Reset (`rst_n` low at an edge):
  - State EMPTY, `owner` 0, `last` 1 (requester 0 wins the first conflict).
  - `resp_result` 0, `resp_flags` 0, `resp_valid` 00.
  - `req_ready` is forced 00 combinationally while `rst_n` is low.
- Latency: accept at edge N gives `resp_valid` high in cycle N+1.
- Throughput: one op per cycle when the owner keeps `resp_ready` high.
- A held response stays stable (result, flags, owner) until drain or flush.
- Reset mid-operation: the held result is lost and no `resp_valid` is issued after reset.
- Starvation: a continuously valid requester is granted within 2 accepts.
- Combinational paths:
  - `req_valid`/`resp_ready` to `req_ready`.
  - Request to `Alu` to register.
  - There are no combinational paths from request inputs to response outputs.

## Structure
- Shared package `alu_arb_pkg`:
  - `NREQ = 2`.
  - State enum `{EMPTY, FULL}`.
  - Response struct `{result, flags, owner}`.
  - Opcode constants are reused from `aluop.svh`, not duplicated.
- Sub-modules:
  - `rr_pick2`: 2-way round-robin grant from `valid` and `last`.
  - `Alu`: the existing module, instantiated once.

## Test plan
- Single SUB: requester 0 sends op 10000, a=20, b=4 → `req_ready[0]` high in the same cycle; next cycle `resp_valid` = 01, `resp_result` = 16, flags equal standalone `Alu` for the same inputs.
- Conflict: both valid in the same cycle after reset (r0 LSL 3,3; r1 LSR 16,2) → r0 granted first and result 24; after drain, r1 granted and result 4; a third conflict grants r0 again.
- Backpressure: r1 issues XOR 31,16 and holds `resp_ready` low for 5 cycles → result 15 stays stable, both `req_ready` stay 0 throughout, and a pending r0 ADD 4,−20 is accepted in the drain cycle, with result 0xFFFF_FFFF_FFFF_FFF0 on the next cycle.
- Back-to-back: r0 streams ORR 31,16 then AND 31,64 with `resp_ready` held high → results 31 then 0 on consecutive cycles, no bubble.
- Flush: FULL with r1's result while r0 is valid and `flush`=1 → `resp_valid` = 00 next cycle, no accept in the flush cycle, r0 accepted the cycle after.
- Reset mid-op: `rst_n` low while FULL and requests are valid → next cycle `resp_valid` = 00, `resp_result` 0, `req_ready` 00 during reset, first post-reset conflict grants r0.
